ethernet_receiver: RTL and testbench

//  Receive side of the Ethernet controller: accepts frames from the MAC rx AXI-Stream, stores them in a
//  2-slot ping-pong packet buffer and exposes the oldest complete frame to the host via packet_r* signals.

---
 rtl/ethernet_receiver.sv | 199 +++++++++++++++++++
 tb/tb_ethernet_receiver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_receiver.sv
// ethernet_receiver
//   Receive side of the Ethernet controller. Frames from the MAC rx AXI-Stream
//   are written into a 2-slot ping-pong packet buffer. The oldest complete frame
//   is exposed to the host, which reads it word by word and acks to free the slot.
//
//   Ports:
//     clk_i, reset_i          clock, asynchronous active-high reset
//     rx_axis_*               MAC rx stream (tready never drops after reset)
//     packet_avail_o/rsize_o  oldest committed frame present / its byte size
//     packet_rvalid_i/raddr_i read request by byte address, data 1 cycle later
//     packet_rdata_o          read data, holds when no request
//     packet_ack_i            release the current frame
//     recv_count_o/drop_count_o  committed / discarded frames, saturating
//
//   Build option:
//     ETHERNET_RECEIVER_DROP_ERR_EN  discard frames flagged by tuser on tlast.
module ethernet_receiver #(
    parameter int data_width_p = 32,
    parameter int eth_mtu_p    = 2048,
    parameter int recv_count_p = 65535
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [data_width_p-1:0]             rx_axis_tdata_i,
    input  logic [data_width_p/8-1:0]           rx_axis_tkeep_i,
    input  logic                                rx_axis_tvalid_i,
    input  logic                                rx_axis_tlast_i,
    input  logic                                rx_axis_tuser_i,
    output logic                                rx_axis_tready_o,
    output logic                                packet_avail_o,
    output logic [$clog2(eth_mtu_p+1)-1:0]      packet_rsize_o,
    input  logic                                packet_rvalid_i,
    input  logic [$clog2(eth_mtu_p)-1:0]        packet_raddr_i,
    output logic [data_width_p-1:0]             packet_rdata_o,
    input  logic                                packet_ack_i,
    output logic [$clog2(recv_count_p+1)-1:0]   recv_count_o,
    output logic [$clog2(recv_count_p+1)-1:0]   drop_count_o
);
    localparam int BYTES_LP = data_width_p / 8;
    localparam int WORDS_LP = eth_mtu_p / BYTES_LP;
    localparam int AW_LP    = $clog2(WORDS_LP);
    localparam int OFS_LP   = $clog2(BYTES_LP);
    localparam int SW_LP    = $clog2(eth_mtu_p + 1);
    localparam int CW_LP    = $clog2(recv_count_p + 1);
    localparam int RA_LP    = $clog2(eth_mtu_p);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_e;

    state_e                      state_q, state_n;
    logic [AW_LP:0]              wptr_q, wptr_n;   // one extra bit to detect overflow
    logic [1:0]                  valid_q, valid_n;
    logic                        wr_slot_q, rd_slot_q, wr_n, rd_n;
    logic [1:0][SW_LP-1:0]       size_q;
    logic                        rdy_q, avail_q, avail_n;
    logic [SW_LP-1:0]            rsize_q, rsize_n;
    logic [data_width_p-1:0]     rdata_q;
    logic [CW_LP-1:0]            recv_q, drop_q;
    logic [data_width_p-1:0]     mem_r [2*WORDS_LP];

    logic                        beat, slot_free, overflow, frame_err, ack_ok;
    logic                        wr_en, commit, drop_evt;
    logic [AW_LP-1:0]            wr_word;
    logic [SW_LP-1:0]            keep_cnt, frame_size;

`ifdef ETHERNET_RECEIVER_DROP_ERR_EN
    assign frame_err = rx_axis_tuser_i;
    logic unused_lo;
    assign unused_lo = ^packet_raddr_i[OFS_LP-1:0];
`else
    assign frame_err = 1'b0;
    logic unused_lo;
    assign unused_lo = ^{packet_raddr_i[OFS_LP-1:0], rx_axis_tuser_i};
`endif

    assign beat      = rx_axis_tvalid_i & rdy_q;
    assign slot_free = ~valid_q[wr_slot_q];
    assign overflow  = (wptr_q == (AW_LP+1)'(WORDS_LP));
    assign ack_ok    = packet_ack_i & avail_q;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < BYTES_LP; i++) keep_cnt = keep_cnt + SW_LP'(rx_axis_tkeep_i[i]);
    end

    // Full words so far plus the bytes of the tlast beat; wptr is 0 in IDLE.
    assign frame_size = SW_LP'({wptr_q, {OFS_LP{1'b0}}}) + keep_cnt;

    // Write FSM next state
    always_comb begin
        state_n  = state_q;
        wptr_n   = wptr_q;
        wr_en    = 1'b0;
        wr_word  = wptr_q[AW_LP-1:0];
        commit   = 1'b0;
        drop_evt = 1'b0;
        if (beat) begin
            case (state_q)
                S_IDLE: begin
                    wr_word = '0;
                    if (!slot_free) begin
                        if (rx_axis_tlast_i) drop_evt = 1'b1;
                        else                 state_n  = S_DROP;
                    end else begin
                        wr_en  = 1'b1;
                        wptr_n = (AW_LP+1)'(1);
                        if (rx_axis_tlast_i) begin
                            if (frame_err) drop_evt = 1'b1;
                            else           commit   = 1'b1;
                        end else begin
                            state_n = S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (overflow) begin
                        if (rx_axis_tlast_i) begin
                            drop_evt = 1'b1;
                            state_n  = S_IDLE;
                        end else begin
                            state_n  = S_DROP;
                        end
                    end else begin
                        wr_en  = 1'b1;
                        wptr_n = wptr_q + (AW_LP+1)'(1);
                        if (rx_axis_tlast_i) begin
                            state_n = S_IDLE;
                            if (frame_err) drop_evt = 1'b1;
                            else           commit   = 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (rx_axis_tlast_i) begin
                        drop_evt = 1'b1;
                        state_n  = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        if (state_n == S_IDLE) wptr_n = '0;
    end

    // Slot bookkeeping. A commit always targets a free slot and an ack a full
    // one, so both can land in the same cycle without conflict.
    always_comb begin
        valid_n = valid_q;
        if (ack_ok) valid_n[rd_slot_q] = 1'b0;
        if (commit) valid_n[wr_slot_q] = 1'b1;
        rd_n    = rd_slot_q ^ ack_ok;
        wr_n    = wr_slot_q ^ commit;
        avail_n = valid_n[rd_n];
        rsize_n = '0;
        if (avail_n) rsize_n = (commit && (wr_slot_q == rd_n)) ? frame_size : size_q[rd_n];
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_r[{wr_slot_q, wr_word}] <= rx_axis_tdata_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            valid_q   <= '0;
            wr_slot_q <= 1'b0;
            rd_slot_q <= 1'b0;
            size_q    <= '0;
            rdy_q     <= 1'b0;
            avail_q   <= 1'b0;
            rsize_q   <= '0;
            rdata_q   <= '0;
            recv_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_n;
            wptr_q    <= wptr_n;
            valid_q   <= valid_n;
            wr_slot_q <= wr_n;
            rd_slot_q <= rd_n;
            rdy_q     <= 1'b1;
            avail_q   <= avail_n;
            rsize_q   <= rsize_n;
            if (commit) size_q[wr_slot_q] <= frame_size;
            if (packet_rvalid_i)
                rdata_q <= mem_r[{rd_slot_q, packet_raddr_i[RA_LP-1:OFS_LP]}];
            if (commit && (recv_q != CW_LP'(recv_count_p)))   recv_q <= recv_q + 1'b1;
            if (drop_evt && (drop_q != CW_LP'(recv_count_p))) drop_q <= drop_q + 1'b1;
        end
    end

    assign rx_axis_tready_o = rdy_q;
    assign packet_avail_o   = avail_q;
    assign packet_rsize_o   = rsize_q;
    assign packet_rdata_o   = rdata_q;
    assign recv_count_o     = recv_q;
    assign drop_count_o     = drop_q;

endmodule

// File: tb/tb_ethernet_receiver.sv
// Testbench for ethernet_receiver: a 32-bit instance (mtu 2048) runs the frame
// table and the multi-cycle corner cases; a 64-bit instance (mtu 256, counter
// saturating at 3) covers the wide datapath and counter saturation.
module tb_ethernet_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_tdata = '0;
    logic [3:0]  a_tkeep = '0;
    logic        a_tvalid = 0, a_tlast = 0, a_tuser = 0, a_rvalid = 0, a_ack = 0;
    logic [10:0] a_raddr = '0;
    logic        a_tready, a_avail;
    logic [11:0] a_rsize;
    logic [31:0] a_rdata;
    logic [15:0] a_recv, a_drop;

    logic [63:0] b_tdata = '0;
    logic [7:0]  b_tkeep = '0;
    logic        b_tvalid = 0, b_tlast = 0, b_tuser = 0, b_rvalid = 0, b_ack = 0;
    logic [7:0]  b_raddr = '0;
    logic        b_tready, b_avail;
    logic [8:0]  b_rsize;
    logic [63:0] b_rdata;
    logic [1:0]  b_recv, b_drop;

    ethernet_receiver #(.data_width_p(32), .eth_mtu_p(2048), .recv_count_p(65535)) u32 (
        .clk_i(clk), .reset_i(rst),
        .rx_axis_tdata_i(a_tdata), .rx_axis_tkeep_i(a_tkeep), .rx_axis_tvalid_i(a_tvalid),
        .rx_axis_tlast_i(a_tlast), .rx_axis_tuser_i(a_tuser), .rx_axis_tready_o(a_tready),
        .packet_avail_o(a_avail), .packet_rsize_o(a_rsize), .packet_rvalid_i(a_rvalid),
        .packet_raddr_i(a_raddr), .packet_rdata_o(a_rdata), .packet_ack_i(a_ack),
        .recv_count_o(a_recv), .drop_count_o(a_drop));

    ethernet_receiver #(.data_width_p(64), .eth_mtu_p(256), .recv_count_p(3)) u64 (
        .clk_i(clk), .reset_i(rst),
        .rx_axis_tdata_i(b_tdata), .rx_axis_tkeep_i(b_tkeep), .rx_axis_tvalid_i(b_tvalid),
        .rx_axis_tlast_i(b_tlast), .rx_axis_tuser_i(b_tuser), .rx_axis_tready_o(b_tready),
        .packet_avail_o(b_avail), .packet_rsize_o(b_rsize), .packet_rvalid_i(b_rvalid),
        .packet_raddr_i(b_raddr), .packet_rdata_o(b_rdata), .packet_ack_i(b_ack),
        .recv_count_o(b_recv), .drop_count_o(b_drop));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int len;       // frame length in bytes
        bit ack_first; // ack the visible frame before sending
        int vis;       // id of the frame expected at the read port afterwards
        int rsize;
        int recv;
        int drop;
    } vec_t;
    vec_t tab[7];

    function automatic logic [7:0] pat(int id, int i);
        return 8'(id * 37 + i * 5 + 1);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send32(int id, int len, bit user, bit ack_last);
        int nb;
        nb = (len + 3) / 4;
        for (int b = 0; b < nb; b++) begin
            int rem;
            rem = len - b * 4;
            for (int j = 0; j < 4; j++) a_tdata[j*8 +: 8] = pat(id, b * 4 + j);
            a_tkeep  = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            a_tvalid = 1'b1;
            a_tlast  = (b == nb - 1);
            a_tuser  = user & a_tlast;
            a_ack    = ack_last & a_tlast;
            tick();
        end
        a_tvalid = 0; a_tlast = 0; a_tuser = 0; a_ack = 0;
    endtask

    task automatic send64(int id, int len);
        int nb;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            int rem;
            rem = len - b * 8;
            for (int j = 0; j < 8; j++) b_tdata[j*8 +: 8] = pat(id, b * 8 + j);
            b_tkeep  = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            b_tvalid = 1'b1;
            b_tlast  = (b == nb - 1);
            tick();
        end
        b_tvalid = 0; b_tlast = 0;
    endtask

    task automatic ack32;
        a_ack = 1'b1; tick(); a_ack = 1'b0;
    endtask

    task automatic ack64;
        b_ack = 1'b1; tick(); b_ack = 1'b0;
    endtask

    task automatic chkframe32(int id, int len);
        logic [31:0] d, e, m;
        for (int w = 0; w < (len + 3) / 4; w++) begin
            a_rvalid = 1'b1; a_raddr = 11'(w * 4);
            tick();
            d = a_rdata; a_rvalid = 1'b0;
            e = '0; m = '0;
            for (int j = 0; j < 4; j++) if (w * 4 + j < len) begin
                e[j*8 +: 8] = pat(id, w * 4 + j);
                m[j*8 +: 8] = 8'hFF;
            end
            chk($sformatf("rd32 f%0d w%0d", id, w), 64'(d & m), 64'(e));
        end
    endtask

    task automatic chkframe64(int id, int len);
        logic [63:0] d, e, m;
        for (int w = 0; w < (len + 7) / 8; w++) begin
            b_rvalid = 1'b1; b_raddr = 8'(w * 8);
            tick();
            d = b_rdata; b_rvalid = 1'b0;
            e = '0; m = '0;
            for (int j = 0; j < 8; j++) if (w * 8 + j < len) begin
                e[j*8 +: 8] = pat(id, w * 8 + j);
                m[j*8 +: 8] = 8'hFF;
            end
            chk($sformatf("rd64 f%0d w%0d", id, w), d & m, e);
        end
    endtask

    initial begin
        //           len   ackf vis rsize recv drop
        tab[0] = '{  64,   0,   0,  64,   1,   0};  // full 32b words
        tab[1] = '{  61,   1,   1,  61,   2,   0};  // partial last beat
        tab[2] = '{   8,   0,   1,  61,   3,   0};  // fills 2nd slot, oldest stays
        tab[3] = '{  20,   0,   1,  61,   3,   1};  // both slots full -> dropped
        tab[4] = '{   4,   1,   2,   8,   4,   1};  // 1-beat frame into freed slot
        tab[5] = '{2052,   1,   4,   4,   4,   2};  // mtu+4 overflow -> dropped
        tab[6] = '{  60,   1,   6,  60,   5,   2};  // normal frame after overflow

        tick(); tick();
        chk("rst tready", 64'(a_tready), 0);
        chk("rst avail",  64'(a_avail), 0);
        chk("rst rsize",  64'(a_rsize), 0);
        chk("rst rdata",  64'(a_rdata), 0);
        chk("rst recv",   64'(a_recv), 0);
        chk("rst drop",   64'(a_drop), 0);
        rst = 1'b0;
        tick();
        chk("tready up32", 64'(a_tready), 1);
        chk("tready up64", 64'(b_tready), 1);

        for (int i = 0; i < 7; i++) begin
            if (tab[i].ack_first) ack32();
            send32(i, tab[i].len, 1'b0, 1'b0);
            tick();
            chk($sformatf("v%0d avail", i), 64'(a_avail), 1);
            chk($sformatf("v%0d rsize", i), 64'(a_rsize), 64'(tab[i].rsize));
            chk($sformatf("v%0d recv", i),  64'(a_recv), 64'(tab[i].recv));
            chk($sformatf("v%0d drop", i),  64'(a_drop), 64'(tab[i].drop));
            chkframe32(tab[i].vis, tab[i].rsize);
        end

        // Commit of frame 7 in the same cycle as ack of frame 6; the slot freed
        // by that ack must take frame 8 starting on the very next cycle.
        send32(7, 12, 1'b0, 1'b1);
        chk("cack avail", 64'(a_avail), 1);
        chk("cack rsize", 64'(a_rsize), 12);
        send32(8, 16, 1'b0, 1'b0);
        chk("cack recv", 64'(a_recv), 7);
        chk("cack drop", 64'(a_drop), 2);
        chk("cack rsize2", 64'(a_rsize), 12);
        chkframe32(7, 12);
        ack32();
        chk("f8 avail", 64'(a_avail), 1);
        chk("f8 rsize", 64'(a_rsize), 16);
        chkframe32(8, 16);
        ack32();
        chk("empty avail", 64'(a_avail), 0);

        // Frame flagged bad on tlast
        send32(9, 16, 1'b1, 1'b0);
        tick();
`ifdef ETHERNET_RECEIVER_DROP_ERR_EN
        chk("err avail", 64'(a_avail), 0);
        chk("err drop",  64'(a_drop), 3);
        chk("err recv",  64'(a_recv), 7);
`else
        chk("err avail", 64'(a_avail), 1);
        chk("err rsize", 64'(a_rsize), 16);
        chk("err recv",  64'(a_recv), 8);
        chk("err drop",  64'(a_drop), 2);
        chkframe32(9, 16);
        ack32();
`endif

        // Reset in the middle of a frame
        for (int b = 0; b < 3; b++) begin
            a_tdata = 32'hDEAD_0000 | 32'(b); a_tkeep = 4'hF; a_tvalid = 1'b1; a_tlast = 1'b0;
            tick();
        end
        rst = 1'b1; a_tvalid = 1'b0;
        tick();
        chk("mrst tready", 64'(a_tready), 0);
        chk("mrst avail",  64'(a_avail), 0);
        chk("mrst rsize",  64'(a_rsize), 0);
        chk("mrst rdata",  64'(a_rdata), 0);
        chk("mrst recv",   64'(a_recv), 0);
        chk("mrst drop",   64'(a_drop), 0);
        rst = 1'b0;
        tick();
        send32(11, 8, 1'b0, 1'b0);
        chk("post avail", 64'(a_avail), 1);
        chk("post rsize", 64'(a_rsize), 8);
        chk("post recv",  64'(a_recv), 1);
        chk("post drop",  64'(a_drop), 0);
        chkframe32(11, 8);

        // 64-bit datapath: 9-byte frame, then counter saturation at 3
        send64(20, 9);
        chk("w64 avail", 64'(b_avail), 1);
        chk("w64 rsize", 64'(b_rsize), 9);
        chk("w64 recv",  64'(b_recv), 1);
        chkframe64(20, 9);
        for (int k = 0; k < 4; k++) begin
            ack64();
            send64(21 + k, 16);
            chk($sformatf("sat%0d avail", k), 64'(b_avail), 1);
            chk($sformatf("sat%0d recv", k), 64'(b_recv), (k == 0) ? 2 : 3);
        end
        chkframe64(24, 16);
        chk("sat drop", 64'(b_drop), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
